// File: rtl/regfile_debug_responder.sv
// Debug-read responder: borrows regfile read port B on grant and returns the value over valid/ready.
// Build option: define REGFILE_DEBUG_COMPARE_EN to build the expected-value compare and error counter.
module regfile_debug_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ERR_CNT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [REG_ADDR_WIDTH-1:0] req_reg,
  input  logic                      req_check,
  input  logic [DATA_WIDTH-1:0]     req_expected,
  output logic                      rf_req,
  input  logic                      rf_grant,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [REG_ADDR_WIDTH-1:0] rsp_reg,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_match,
  output logic                      rsp_timeout,
  output logic [ERR_CNT_WIDTH-1:0]  error_count
);

  typedef enum logic [1:0] {IDLE, ARB, READ, RESP} state_t;

  state_t                    state;
  logic [15:0]               wait_cnt;
  logic [REG_ADDR_WIDTH-1:0] lat_reg;
  logic                      accept;
  logic                      zero_reg;
  logic                      timeout_hit;
  logic                      idle_match;
  logic                      read_match;

  assign accept      = (state == IDLE) && req_valid && req_ready;
  assign zero_reg    = (req_reg == '0);
  // A grant in the final wait cycle beats the timeout.
  assign timeout_hit = !rf_grant && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

`ifdef REGFILE_DEBUG_COMPARE_EN
  logic                     lat_check;
  logic [DATA_WIDTH-1:0]    lat_expected;
  logic                     err_event;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  assign idle_match = !req_check || (req_expected == '0);
  assign read_match = !lat_check || (rf_data == lat_expected);

  always_comb begin
    // NOTE: default first so every path assigns err_event and no latch is inferred.
    err_event = 1'b0;
    case (state)
      IDLE:    err_event = accept && zero_reg && !idle_match;
      ARB:     err_event = (state == ARB) && timeout_hit && lat_check;
      READ:    err_event = !read_match;
      default: err_event = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_check    <= 1'b0;
      lat_expected <= '0;
    end else if (accept) begin
      lat_check    <= req_check;
      lat_expected <= req_expected;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_event && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign error_count = err_cnt;
`else
  logic unused_compare;
  assign unused_compare = req_check ^ (^req_expected);
  assign idle_match     = 1'b1;
  assign read_match     = 1'b1;
  assign error_count    = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      wait_cnt    <= '0;
      lat_reg     <= '0;
      rf_req      <= 1'b0;
      rf_addr     <= '0;
      rsp_valid   <= 1'b0;
      rsp_reg     <= '0;
      rsp_data    <= '0;
      rsp_match   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register updates from pre-edge values.
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            lat_reg   <= req_reg;
            wait_cnt  <= '0;
            if (zero_reg) begin
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_reg     <= '0;
              rsp_data    <= '0;
              rsp_match   <= idle_match;
              rsp_timeout <= 1'b0;
            end else begin
              state   <= ARB;
              rf_req  <= 1'b1;
              rf_addr <= req_reg;
            end
          end
        end
        ARB: begin
          if (rf_grant) begin
            state   <= READ;
            rf_req  <= 1'b0;
            rf_addr <= '0;
          end else if (timeout_hit) begin
            state       <= RESP;
            rf_req      <= 1'b0;
            rf_addr     <= '0;
            rsp_valid   <= 1'b1;
            rsp_reg     <= lat_reg;
            rsp_data    <= '0;
            rsp_match   <= 1'b0;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        READ: begin
          state       <= RESP;
          rsp_valid   <= 1'b1;
          rsp_reg     <= lat_reg;
          rsp_data    <= rf_data;
          rsp_match   <= read_match;
          rsp_timeout <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
